pixel_unpacker: RTL and testbench
=================================

# pixel_unpacker

Receive-side counterpart of the RGB-to-AXI-Stream packer. Accepts a 32-bit AXI4-Stream of tightly packed 24-bit pixels (3 words carry 4 pixels) and emits one RGB888 pixel per handshake with start-of-frame and end-of-line markers. It sits between a DMA/VDMA MM2S stream and downstream pixel-domain logic such as a display pipeline or a CNN input buffer.

## Interface
- No parameters.
- aclk  input  1  clock.
- aresetn  input  1  reset; synchronous, active-low; clock aclk.
- in_stream_tdata  input  32  packed pixel bytes, byte 0 in [7:0].
- in_stream_tkeep  input  4  ignored; upstream always drives 4'hf.
- in_stream_tlast  input  1  word completes the last pixel of a line.
- in_stream_tuser  input  1  word carries the first pixel of a frame.
- in_stream_tvalid  input  1  word valid.
- in_stream_tready  output  1  word accepted when high with tvalid.
- r, g, b  output  8 each  pixel colour, registered.
- out_valid  output  1  pixel valid, registered.
- out_ready  input  1  downstream accepts pixel.
- sof  output  1  pixel is first of frame; qualified by out_valid.
- eol  output  1  pixel is last of line; qualified by out_valid.
- err_align  output  1  one-cycle pulse on framing error.

## Operation
- Byte stream order per pixel is G, B, R; bytes consumed little-endian (tdata[7:0] first).
- Group of 3 words → 4 pixels: W0 = {G1,R0,B0,G0}, W1 = {B2,G2,R1,B1}, W2 = {R3,B3,G3,R2} (MSB..LSB).
- State: phase (0..3), leftover register (24 bits), pending_eol flag.
- load = ~out_valid | out_ready. Output register updates only when load.
- in_stream_tready = aresetn & load & (phase != 3).
- Phase 0, word accepted: pixel {G0,B0,R0} = tdata[7:0],[15:8],[23:16]; leftover[7:0] ← tdata[31:24]; phase → 1.
- Phase 1, word accepted: pixel {G1,B1,R1} = leftover[7:0], tdata[7:0], tdata[15:8]; leftover[15:0] ← tdata[31:16]; phase → 2.
- Phase 2, word accepted: pixel {G2,B2,R2} = leftover[7:0], leftover[15:8], tdata[7:0]; leftover ← tdata[31:8]; pending_eol ← tlast; phase → 3.
- Phase 3, load (no word consumed): pixel {G3,B3,R3} = leftover[7:0],[15:8],[23:16]; eol ← pending_eol; phase → 0.
- sof: set on the pixel produced from the word with tuser=1; 0 on all others.
- tuser=1 accepted in phase 1 or 2: resynchronise — discard leftover, decode word as phase 0, phase → 1, err_align pulse.
- tlast=1 accepted in phase 0 or 1: that pixel gets eol=1, phase → 0, leftover discarded, err_align pulse.
- tlast=1 in phase 2 is the normal end of line; eol appears on the following phase-3 pixel, not the phase-2 pixel.
- Lines must be a multiple of 4 pixels; no partial-group handling beyond the error rule above.

## Timing
- Reset (aresetn low at a clock edge): out_valid=0, sof=0, eol=0, err_align=0, r=g=b=0, phase=0, pending_eol=0, leftover=0; in_stream_tready low while aresetn low.
- Reset mid-group discards leftover; the first word after reset decodes as phase 0.
- Latency: pixel visible on outputs one cycle after its word handshake; phase-3 pixel one cycle after the phase-2 pixel is consumed.
- Throughput with out_ready=1: 4 pixels in 4 cycles, 3 words accepted per 4 cycles (tready low in phase 3).
- out_ready=0 with out_valid=1: r,g,b,sof,eol,out_valid hold; tready=0; phase frozen.
- in_stream_tready depends combinationally on out_ready; no combinational path from tvalid to out_valid.
- err_align is high for exactly one cycle, coincident with out_valid rising for the offending pixel.

## Test plan
- Words 0x44332211, 0x88776655, 0xCCBBAA99 (tuser on first, tlast on third), out_ready=1 → pixels (g,b,r) = (11,22,33) sof=1, (44,55,66), (77,88,99), (AA,BB,CC) eol=1; tready low on the 4th cycle only.
- Same stream with out_ready toggling 1/0 every cycle → identical pixel sequence, each pixel held while out_ready=0, no word lost or duplicated.
- 8-pixel line (6 words) back-to-back with second group continuing → 8 pixels, eol only on pixel 8, phase 0 after.
- tuser=1 on word 2 of a group → err_align pulse, that word decodes as phase-0 pixel with sof=1, next 3 pixels correct.
- tlast=1 on word 1 of a group → pixel 1 has eol=1, err_align pulse, next word decodes as phase 0.
- aresetn asserted while phase=2 with out_valid=1 → next cycle all outputs 0; following stream decodes from phase 0 correctly.

Source files
------------

// File: rtl/pixel_unpacker_if.sv
// Stream-side and pixel-side handshake bundle for pixel_unpacker.
// master = producer of packed words / consumer of pixels, slave = the unpacker.
interface pixel_unpacker_if;
  logic [31:0] in_stream_tdata;
  logic [3:0]  in_stream_tkeep;
  logic        in_stream_tlast;
  logic        in_stream_tuser;
  logic        in_stream_tvalid;
  logic        in_stream_tready;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic        sof;
  logic        eol;
  logic        err_align;

  modport master (
    output in_stream_tdata, in_stream_tkeep, in_stream_tlast, in_stream_tuser, in_stream_tvalid,
    input  in_stream_tready,
    input  r, g, b, out_valid, sof, eol, err_align,
    output out_ready
  );

  modport slave (
    input  in_stream_tdata, in_stream_tkeep, in_stream_tlast, in_stream_tuser, in_stream_tvalid,
    output in_stream_tready,
    output r, g, b, out_valid, sof, eol, err_align,
    input  out_ready
  );
endinterface

// File: rtl/pixel_unpacker.sv
// Unpacks a 32-bit stream of tightly packed 24-bit pixels (3 words -> 4 pixels)
// into one registered RGB888 pixel per handshake, with sof/eol markers.
module pixel_unpacker (
  input  logic          aclk,
  input  logic          aresetn,
  pixel_unpacker_if.slave io
);
  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

  phase_t      phase;
  logic [23:0] leftover;
  logic        pending_eol;
  logic        load;
  logic        accept;
  logic        resync;
  logic        early_last;
  logic [31:0] d;
  logic        unused_keep;

  assign d           = io.in_stream_tdata;
  assign unused_keep = ^io.in_stream_tkeep;
  assign load        = ~io.out_valid | io.out_ready;
  assign io.in_stream_tready = aresetn & load & (phase != PH3);
  assign accept      = io.in_stream_tvalid & io.in_stream_tready;
  // A frame start arriving mid-group restarts decoding as if it were word 0.
  assign resync      = io.in_stream_tuser & ((phase == PH1) | (phase == PH2));
  // tlast is only legal on the third word of a group; anywhere else it truncates the group.
  assign early_last  = io.in_stream_tlast & (resync | (phase != PH2));

  // NOTE: all state here is sequential, so every assignment is non-blocking; the
  // leftover bytes are reset too, so a reset mid-group can never leak stale colour.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      phase        <= PH0;
      leftover     <= '0;
      pending_eol  <= 1'b0;
      io.out_valid <= 1'b0;
      io.sof       <= 1'b0;
      io.eol       <= 1'b0;
      io.err_align <= 1'b0;
      io.r         <= '0;
      io.g         <= '0;
      io.b         <= '0;
    end else begin
      io.err_align <= 1'b0;
      if (load) begin
        if (accept) begin
          io.out_valid <= 1'b1;
          io.sof       <= io.in_stream_tuser;
          io.eol       <= early_last;
          io.err_align <= resync | early_last;
          if (phase == PH0 || resync) begin
            io.g     <= d[7:0];
            io.b     <= d[15:8];
            io.r     <= d[23:16];
            leftover <= early_last ? 24'h0 : {16'h0, d[31:24]};
            phase    <= early_last ? PH0 : PH1;
          end else if (phase == PH1) begin
            io.g     <= leftover[7:0];
            io.b     <= d[7:0];
            io.r     <= d[15:8];
            leftover <= early_last ? 24'h0 : {8'h0, d[31:16]};
            phase    <= early_last ? PH0 : PH2;
          end else begin
            io.g        <= leftover[7:0];
            io.b        <= leftover[15:8];
            io.r        <= d[7:0];
            leftover    <= d[31:8];
            pending_eol <= io.in_stream_tlast;
            phase       <= PH3;
          end
        end else if (phase == PH3) begin
          // Fourth pixel of the group comes entirely from the leftover bytes.
          io.out_valid <= 1'b1;
          io.sof       <= 1'b0;
          io.eol       <= pending_eol;
          io.g         <= leftover[7:0];
          io.b         <= leftover[15:8];
          io.r         <= leftover[23:16];
          pending_eol  <= 1'b0;
          phase        <= PH0;
        end else begin
          io.out_valid <= 1'b0;
          io.sof       <= 1'b0;
          io.eol       <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pixel_unpacker.sv
// Self-checking bench for pixel_unpacker: byte-queue reference model, per-cycle
// output compare, directed scenarios with literal expectations, and random traffic.
module tb_pixel_unpacker;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  pixel_unpacker_if io();

  pixel_unpacker dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .io      (io.slave)
  );

  typedef struct {
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] r;
    bit         sof;
    bit         eol;
    bit         err;
  } pix_t;

  pix_t       exp_q[$];
  pix_t       seen[$];
  logic [7:0] bq[$];
  bit         tr_log[$];
  int         widx = 0;
  int         checks = 0;
  int         failures = 0;
  bit         in_reset = 1'b1;
  int         rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes stream in G,B,R order; a group is three words.
  task automatic model_word(input logic [31:0] d, input bit user, input bit last);
    pix_t p;
    bit   err;
    bit   first;
    err   = 1'b0;
    first = 1'b1;
    if (user && widx != 0) begin
      err = 1'b1;
      bq.delete();
      widx = 0;
    end
    for (int i = 0; i < 4; i++) bq.push_back(d[8*i +: 8]);
    if (last && widx < 2) begin
      p.g = bq[0]; p.b = bq[1]; p.r = bq[2];
      p.sof = user; p.eol = 1'b1; p.err = 1'b1;
      exp_q.push_back(p);
      bq.delete();
      widx = 0;
    end else begin
      while (bq.size() >= 3) begin
        p.g   = bq.pop_front();
        p.b   = bq.pop_front();
        p.r   = bq.pop_front();
        p.sof = first && user;
        p.err = first && err;
        p.eol = last && (bq.size() == 0);
        first = 1'b0;
        exp_q.push_back(p);
      end
      widx = (widx + 1) % 3;
    end
  endtask

  // Output compare: a fresh pixel is checked against the model, a stalled one must hold.
  pix_t cur;
  bit   prev_valid = 1'b0;
  bit   prev_taken = 1'b0;
  always @(negedge aclk) begin
    pix_t a;
    if (in_reset) begin
      prev_valid = 1'b0;
      prev_taken = 1'b0;
    end else begin
      if (io.out_valid) begin
        if (!prev_valid || prev_taken) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pixel", 32'(exp_q.size()), 32'd1);
          end else begin
            cur = exp_q.pop_front();
            check("pixel", {5'd0, io.r, io.g, io.b, io.sof, io.eol, io.err_align},
                           {5'd0, cur.r, cur.g, cur.b, cur.sof, cur.eol, cur.err});
            a.g = io.g; a.b = io.b; a.r = io.r;
            a.sof = io.sof; a.eol = io.eol; a.err = io.err_align;
            seen.push_back(a);
          end
        end else begin
          check("hold", {6'd0, io.r, io.g, io.b, io.sof, io.eol},
                        {6'd0, cur.r, cur.g, cur.b, cur.sof, cur.eol});
          check("err_pulse_width", 32'(io.err_align), 32'd0);
        end
      end else begin
        check("err_idle", 32'(io.err_align), 32'd0);
      end
      prev_valid = io.out_valid;
      prev_taken = io.out_valid & io.out_ready;
    end
  end

  initial begin
    io.out_ready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       io.out_ready = 1'b1;
        1:       io.out_ready = ~io.out_ready;
        default: io.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input logic [31:0] d, input bit user, input bit last);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    io.in_stream_tdata  = d;
    io.in_stream_tuser  = user;
    io.in_stream_tlast  = last;
    io.in_stream_tvalid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge aclk);
      acc = io.in_stream_tready;
      tr_log.push_back(acc);
      @(posedge aclk);
      #1;
      n++;
    end
    io.in_stream_tvalid = 1'b0;
    check("send_accept", 32'(acc), 32'd1);
    if (acc) model_word(d, user, last);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge aclk);
    @(posedge aclk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    aresetn  = 1'b0;
    io.in_stream_tvalid = 1'b0;
    @(negedge aclk);
    check("tready_in_reset", 32'(io.in_stream_tready), 32'd0);
    @(posedge aclk);
    #1;
    @(negedge aclk);
    check("rst_out_valid", 32'(io.out_valid), 32'd0);
    check("rst_flags", {29'd0, io.sof, io.eol, io.err_align}, 32'd0);
    check("rst_rgb", {8'd0, io.r, io.g, io.b}, 32'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    exp_q.delete();
    bq.delete();
    widx = 0;
    in_reset = 1'b0;
  endtask

  task automatic check_pix(input string name, input int idx, input logic [7:0] g,
                           input logic [7:0] b, input logic [7:0] r, input bit sof, input bit eol);
    if (idx < seen.size())
      check(name, {3'd0, seen[idx].g, seen[idx].b, seen[idx].r, seen[idx].sof, seen[idx].eol},
                  {3'd0, g, b, r, sof, eol});
    else
      check({name, "_missing"}, 32'(seen.size()), 32'(idx + 1));
  endtask

  task automatic basic_group();
    send(32'h44332211, 1'b1, 1'b0);
    send(32'h88776655, 1'b0, 1'b0);
    send(32'hCCBBAA99, 1'b0, 1'b1);
  endtask

  task automatic check_basic(input string tag);
    check({tag, "_count"}, 32'(seen.size()), 32'd4);
    check_pix({tag, "_p0"}, 0, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0);
    check_pix({tag, "_p1"}, 1, 8'h44, 8'h55, 8'h66, 1'b0, 1'b0);
    check_pix({tag, "_p2"}, 2, 8'h77, 8'h88, 8'h99, 1'b0, 1'b0);
    check_pix({tag, "_p3"}, 3, 8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  initial begin
    io.in_stream_tdata  = '0;
    io.in_stream_tkeep  = 4'hf;
    io.in_stream_tlast  = 1'b0;
    io.in_stream_tuser  = 1'b0;
    io.in_stream_tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    do_reset();

    // Basic group at full rate, including the tready gap in phase 3.
    rdy_mode = 0;
    seen.delete();
    tr_log.delete();
    basic_group();
    check("tready_first3", {29'd0, tr_log.size() == 3, tr_log[0], tr_log[1] & tr_log[2]}, 32'd7);
    @(negedge aclk);
    check("tready_phase3", 32'(io.in_stream_tready), 32'd0);
    @(posedge aclk);
    #1;
    @(negedge aclk);
    check("tready_after_group", 32'(io.in_stream_tready), 32'd1);
    drain();
    check_basic("basic");

    // Same stream with out_ready toggling every cycle.
    rdy_mode = 1;
    seen.delete();
    basic_group();
    drain();
    check_basic("toggle");

    // 8-pixel line: eol only on the last pixel, sof only on the first.
    rdy_mode = 0;
    seen.delete();
    for (int i = 0; i < 6; i++) send($urandom, i == 0, i == 5);
    drain();
    check("line8_count", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++)
      check("line8_marks", {30'd0, seen[i].sof, seen[i].eol}, {30'd0, i == 0, i == 7});

    // tuser on the second word of a group: resynchronise.
    seen.delete();
    send(32'h03020100, 1'b1, 1'b0);
    send(32'h13121110, 1'b1, 1'b0);
    send(32'h17161514, 1'b0, 1'b0);
    send(32'h1B1A1918, 1'b0, 1'b1);
    drain();
    check_pix("resync_p0", 0, 8'h00, 8'h01, 8'h02, 1'b1, 1'b0);
    check_pix("resync_p1", 1, 8'h10, 8'h11, 8'h12, 1'b1, 1'b0);
    check_pix("resync_p2", 2, 8'h13, 8'h14, 8'h15, 1'b0, 1'b0);
    check_pix("resync_p4", 4, 8'h19, 8'h1A, 8'h1B, 1'b0, 1'b1);
    if (seen.size() > 1) check("resync_err", {30'd0, seen[0].err, seen[1].err}, 32'd1);

    // tlast on the first word of a group: truncated line.
    seen.delete();
    send(32'h55443322, 1'b1, 1'b1);
    send(32'h23222120, 1'b0, 1'b0);
    send(32'h27262524, 1'b0, 1'b0);
    send(32'h2B2A2928, 1'b0, 1'b1);
    drain();
    check_pix("early_last_p0", 0, 8'h22, 8'h33, 8'h44, 1'b1, 1'b1);
    check_pix("early_last_p1", 1, 8'h20, 8'h21, 8'h22, 1'b0, 1'b0);
    if (seen.size() > 0) check("early_last_err", 32'(seen[0].err), 32'd1);

    // Reset while in phase 2 with a pixel on the output.
    send(32'h63626160, 1'b1, 1'b0);
    send(32'h67666564, 1'b0, 1'b0);
    do_reset();
    seen.delete();
    basic_group();
    drain();
    check_basic("post_reset");

    // Random traffic with random backpressure and sparse framing markers.
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge aclk);
        #1;
      end
      send($urandom, $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
